// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signal bundle between the pipeline and
// the branch predictor. "master" is the pipeline side, "slave" the predictor.
interface branch_predictor_if;
  // fetch lookup
  logic [31:0] i_pc_if;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  // execute-stage resolution
  logic        i_upd_vld;
  logic [31:0] i_upd_pc;
  logic        i_upd_cond;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        o_mispred;
  logic [31:0] o_redirect_pc;
  // statistics
  logic [31:0] o_stat_ctrl;
  logic [31:0] o_stat_mispred;

  modport master (
    output i_pc_if, i_upd_vld, i_upd_pc, i_upd_cond, i_upd_taken,
           i_upd_target, i_upd_pred_taken, i_upd_pred_target,
    input  o_pred_taken, o_pred_target, o_mispred, o_redirect_pc,
           o_stat_ctrl, o_stat_mispred
  );

  modport slave (
    input  i_pc_if, i_upd_vld, i_upd_pc, i_upd_cond, i_upd_taken,
           i_upd_target, i_upd_pred_taken, i_upd_pred_target,
    output o_pred_taken, o_pred_target, o_mispred, o_redirect_pc,
           o_stat_ctrl, o_stat_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters. Zero-latency lookup
// for IF, training/mispredict detection from EX, and branch statistics.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int MODE    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam bit DYN   = (MODE != 0);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_MAX  = {CTR_W{1'b1}};
  localparam ctr_t CTR_WEAK = ctr_t'(1) << (CTR_W - 1);

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        cond;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } upd_req_t;

  // table state: valid/ctr are reset, tag/target are qualified by valid
  logic [ENTRIES-1:0] valid_q;
  ctr_t               ctr_q [ENTRIES];
  tag_t               tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [31:0] stat_ctrl_q;
  logic [31:0] stat_mis_q;

  upd_req_t upd;
  assign upd = '{vld:         bp.i_upd_vld,
                 pc:          bp.i_upd_pc,
                 cond:        bp.i_upd_cond,
                 taken:       bp.i_upd_taken,
                 target:      bp.i_upd_target,
                 pred_taken:  bp.i_upd_pred_taken,
                 pred_target: bp.i_upd_pred_target};

  // ---------------- lookup (combinational, pre-update contents) -----------
  idx_t rd_idx;
  tag_t rd_tag;
  logic rd_hit;
  logic pred_taken;

  assign rd_idx     = bp.i_pc_if[IDX_W+1:2];
  assign rd_tag     = bp.i_pc_if[31:IDX_W+2];
  assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken = DYN && rd_hit && ctr_q[rd_idx][CTR_W-1];

  assign bp.o_pred_taken  = pred_taken;
  assign bp.o_pred_target = pred_taken ? tgt_q[rd_idx] : bp.i_pc_if + 32'd4;

  // ---------------- mispredict / redirect ---------------------------------
  logic mispred;
  assign mispred = upd.vld && ((upd.pred_taken != upd.taken) ||
                               (upd.taken && (upd.pred_target != upd.target)));

  assign bp.o_mispred     = mispred;
  assign bp.o_redirect_pc = upd.taken ? upd.target : upd.pc + 32'd4;

  // ---------------- training decision --------------------------------------
  idx_t wr_idx;
  tag_t wr_tag;
  logic wr_hit;
  logic tab_we;
  logic tgt_we;
  ctr_t ctr_cur;
  ctr_t ctr_nxt;

  assign wr_idx  = upd.pc[IDX_W+1:2];
  assign wr_tag  = upd.pc[31:IDX_W+2];
  assign wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign ctr_cur = ctr_q[wr_idx];
  // a conditional not-taken miss is the only resolved case that leaves the table alone
  assign tab_we  = DYN && upd.vld && (wr_hit || upd.taken);
  assign tgt_we  = tab_we && (upd.taken || !upd.cond);

  // next counter value for the written entry
  always_comb begin
    ctr_nxt = ctr_cur;
    if (!wr_hit)
      ctr_nxt = upd.cond ? CTR_WEAK : CTR_MAX;
    else if (!upd.cond)
      ctr_nxt = CTR_MAX;
    else if (upd.taken)
      ctr_nxt = (ctr_cur == CTR_MAX) ? CTR_MAX : ctr_cur + ctr_t'(1);
    else
      ctr_nxt = (ctr_cur == '0) ? '0 : ctr_cur - ctr_t'(1);
  end

  // valid bits and direction counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (tab_we) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= ctr_nxt;
    end
  end

  // tag and target payload; no reset needed since valid gates every use
  always_ff @(posedge i_clk) begin
    if (tgt_we && !i_rst) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= upd.target;
    end
  end

  // statistics, counted in both modes, wrapping mod 2^32
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_ctrl_q <= '0;
      stat_mis_q  <= '0;
    end else if (upd.vld) begin
      stat_ctrl_q <= stat_ctrl_q + 32'd1;
      if (mispred) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bp.o_stat_ctrl    = stat_ctrl_q;
  assign bp.o_stat_mispred = stat_mis_q;

  // word-aligned PCs: the low two bits carry no information here
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.i_pc_if[1:0], upd.pc[1:0]};
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage RV32I pipeline; replaces the always-not-taken / redirect-on-taken behaviour of the non-forwarding model. The IF stage looks up the fetch PC and gets a predicted direction and target in the same cycle. The EX stage reports each resolved control instruction. The block trains a direct-mapped BTB with saturating direction counters, flags mispredictions with the correct redirect PC, and keeps retire-independent branch statistics.

## Interface
Parameters:
- ENTRIES, 64: BTB/counter entries; power of two, 2..1024; IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, 1..4.
- MODE, 1: 0 = static not-taken (tables unused, o_pred_taken always 0); 1 = dynamic.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_pc_if  in  32  fetch PC to predict.
- o_pred_taken  out  1  predicted taken for i_pc_if (combinational).
- o_pred_target  out  32  predicted target; i_pc_if+4 when o_pred_taken=0.
- i_upd_vld  in  1  EX holds a valid, non-bubble control instruction this cycle.
- i_upd_pc  in  32  PC of resolving instruction.
- i_upd_cond  in  1  1 = conditional branch, 0 = JAL/JALR.
- i_upd_taken  in  1  actual outcome (forced 1 for JAL/JALR by caller).
- i_upd_target  in  32  actual taken target.
- i_upd_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- i_upd_pred_target  in  32  predicted target carried down the pipeline.
- o_mispred  out  1  combinational; flush IF/ID and ID/EX and redirect.
- o_redirect_pc  out  32  correct next PC when o_mispred=1.
- o_stat_ctrl  out  32  count of resolved control instructions.
- o_stat_mispred  out  32  count of mispredictions.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0], ctr[CTR_W-1:0].
- Lookup (MODE=1): hit = valid & tag match. o_pred_taken = hit & ctr[CTR_W-1]. o_pred_target = entry target if o_pred_taken, else i_pc_if+4 (32-bit wrap).
- Misprediction: o_mispred = i_upd_vld & ((i_upd_pred_taken != i_upd_taken) | (i_upd_taken & i_upd_pred_target != i_upd_target)).
- o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc+4.
- Update when i_upd_vld=1 and MODE=1, at the entry indexed by i_upd_pc:
  - Hit, conditional: ctr saturating +1 if taken, -1 if not taken. Bounds are 0 and 2^CTR_W-1. Target is rewritten when taken.
  - Hit, JAL/JALR: ctr set to max; target rewritten (covers JALR target changes).
  - Miss, taken: allocate, overwriting any conflicting entry. valid=1, tag and target written. ctr = 2^(CTR_W-1) for conditional (weakly taken), max for JAL/JALR.
  - Miss, conditional not taken: no allocation, table unchanged.
- Statistics: when i_upd_vld, o_stat_ctrl increments. When o_mispred, o_stat_mispred also increments. Both counters wrap mod 2^32. Counting is active in both modes.
- MODE=0: o_pred_taken=0, o_pred_target=i_pc_if+4. The table is never written. Mispredict reduces to "taken".

## Timing
- Lookup: zero latency, combinational from i_pc_if. No registered outputs on the prediction path.
- Update: written on the rising edge of the cycle where i_upd_vld=1. A lookup first sees the new contents the following cycle.
- Same-index lookup and update in one cycle: lookup returns pre-update contents. No bypass.
- o_mispred and o_redirect_pc are combinational from the update inputs, valid in the same cycle as i_upd_vld.
- i_upd_vld=0 cycles (bubbles, flushed slots) change no state.
- Reset (asynchronous, any time including mid-update) clears all valid bits, all ctr to 0, and both stat counters to 0. Targets and tags need no reset.
- After reset, all lookups predict not-taken with o_pred_target = i_pc_if+4. o_mispred is driven purely by its inputs.

## Test plan
- Reset then lookup 0x0000_0100 -> o_pred_taken=0, o_pred_target=0x104; stats 0.
- Update with pc 0x100, cond, taken, target 0x80, pred_taken=0 -> o_mispred=1, redirect 0x80. Next cycle lookup 0x100 gives taken/0x80 (ctr=2); o_stat_mispred=1.
- Same entry: three not-taken updates -> ctr 2→1→0→0 (saturates). Lookup not taken; the first not-taken update flags mispred with redirect 0x104.
- JALR at 0x200 resolved to 0x300 then 0x340, predictions carried correctly -> second update mispred (target mismatch), redirect 0x340; lookup then gives 0x340.
- ENTRIES=64: alias 0x100 and 0x200 (same index, different tag), both taken -> the second evicts the first. Lookup 0x100 then misses (not taken).
- Assert reset during an update cycle with i_upd_vld=1 -> entry not written; stats 0 after reset. In MODE=0, predictions are always not taken and the table stays invalid.
